// File: rtl/ecpri_mem_arb_pkg.sv
// Shared definitions for the eCPRI payload memory arbiter: default widths,
// requester indices and FSM state encoding.
package ecpri_mem_arb_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ADDR_WIDTH = 16;
    localparam int unsigned DEF_NUM_REQ    = 3;
    localparam int unsigned DEF_LEN_WIDTH  = 8;

    localparam int unsigned REQ_RX   = 0;
    localparam int unsigned REQ_TX   = 1;
    localparam int unsigned REQ_HOST = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BURST   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

endpackage

// File: rtl/ecpri_rr_pick.sv
// Combinational round-robin picker: scans from (last+1) mod NUM_REQ and
// returns the first requesting index.
module ecpri_rr_pick #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   win,
    output logic               any_req
);

    int unsigned      idx;
    logic [IDX_W-1:0] sel;

    always_comb begin
        win     = last;
        any_req = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(last) + 32'd1 + i) % NUM_REQ;
            sel = IDX_W'(idx);
            if (!any_req && req[sel]) begin
                any_req = 1'b1;
                win     = sel;
            end
        end
    end

endmodule

// File: rtl/ecpri_mem_arb.sv
// Round-robin arbiter and burst sequencer for the single-port eCPRI payload
// memory; one beat per cycle for the granted requester until done or abort.
module ecpri_mem_arb
    import ecpri_mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            beat,
    output logic [NUM_REQ-1:0]            done,
    output logic                          abort,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_data,
    output logic                          mem_we,
    output logic                          mem_oe,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [NUM_REQ-1:0]            rd_valid
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
    logic [LEN_WIDTH-1:0]  len_a   [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign addr_a[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign len_a[g]   = req_len[g*LEN_WIDTH +: LEN_WIDTH];
        assign wdata_a[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    state_e                state_q, state_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [IDX_W-1:0]      win_q, win_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic                  we_q, we_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  zl_q, zl_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [NUM_REQ-1:0]    rd_valid_q, rd_valid_d;

    logic [IDX_W-1:0] pick;
    logic             any_req;

    ecpri_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (req),
        .last    (win_q),
        .win     (pick),
        .any_req (any_req)
    );

    logic win_req;
    logic in_burst;
    logic last_beat;

    assign win_req   = req[win_q];
    assign in_burst  = (state_q == ST_BURST);
    assign last_beat = (cnt_q == (len_q - LEN_WIDTH'(1)));

    // Memory strobes, beat/done/abort decode from registered state and the
    // live request of the current winner (a dropped request aborts this cycle).
    always_comb begin
        beat     = '0;
        done     = '0;
        abort    = 1'b0;
        mem_we   = 1'b0;
        mem_oe   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        if (in_burst) begin
            if (win_req) begin
                beat[win_q] = 1'b1;
                mem_addr    = base_q + ADDR_WIDTH'(cnt_q);
                mem_we      = we_q;
                mem_oe      = !we_q;
                if (we_q) begin
                    mem_data = wdata_a[win_q];
                end
                if (last_beat) begin
                    done[win_q] = 1'b1;
                end
            end else begin
                done[win_q] = 1'b1;
                abort       = 1'b1;
            end
        end else if (state_q == ST_RELEASE && zl_q) begin
            done[win_q] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        win_d      = win_q;
        base_d     = base_q;
        len_d      = len_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        zl_d       = zl_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = '0;

        if (in_burst && win_req && !we_q) begin
            rd_data_d         = mem_rdata;
            rd_valid_d[win_q] = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    win_d  = pick;
                    base_d = addr_a[pick];
                    len_d  = len_a[pick];
                    we_d   = req_we[pick];
                    cnt_d  = '0;
                    gnt_d  = '0;
                    if (len_a[pick] == '0) begin
                        zl_d    = 1'b1;
                        state_d = ST_RELEASE;
                    end else begin
                        zl_d        = 1'b0;
                        gnt_d[pick] = 1'b1;
                        state_d     = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                if (!win_req || last_beat) begin
                    gnt_d   = '0;
                    state_d = ST_RELEASE;
                end
                if (win_req) begin
                    cnt_d = cnt_q + LEN_WIDTH'(1);
                end
            end
            ST_RELEASE: begin
                zl_d    = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                zl_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            win_q      <= IDX_W'(NUM_REQ - 1);
            base_q     <= '0;
            len_q      <= '0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            zl_q       <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            win_q      <= win_d;
            base_q     <= base_d;
            len_q      <= len_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            zl_q       <= zl_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign gnt      = gnt_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ecpri_mem_arb.sv
// Directed bench for ecpri_mem_arb: write/read bursts, round-robin order,
// address wrap, zero length, abort and asynchronous reset.
module tb_ecpri_mem_arb;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [15:0] ra [3];
    logic [7:0]  rl [3];
    logic [7:0]  wd [3];
    logic [2:0]  rwe;
    logic [47:0] req_addr;
    logic [23:0] req_len;
    logic [23:0] req_wdata;
    logic [2:0]  gnt, beat, done, rd_valid;
    logic        abort, mem_we, mem_oe;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data, mem_rdata, rd_data;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int nw;

    assign req_addr  = {ra[2], ra[1], ra[0]};
    assign req_len   = {rl[2], rl[1], rl[0]};
    assign req_wdata = {wd[2], wd[1], wd[0]};

    ecpri_mem_arb dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_we    (rwe),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .beat      (beat),
        .done      (done),
        .abort     (abort),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_we    (mem_we),
        .mem_oe    (mem_oe),
        .mem_rdata (mem_rdata),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid)
    );

    // Preloaded read-only memory image
    always_comb begin
        case (mem_addr)
            16'h0100: mem_rdata = 8'h11;
            16'h0101: mem_rdata = 8'h22;
            16'h0102: mem_rdata = 8'h33;
            default:  mem_rdata = 8'h00;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".gnt"}, 32'(gnt), 32'h0);
        chk({tag, ".beat"}, 32'(beat), 32'h0);
        chk({tag, ".strb"}, 32'({mem_we, mem_oe}), 32'h0);
    endtask

    // Exclusivity invariants sampled every cycle
    always @(negedge clk) begin
        chk("excl.we_oe", 32'(mem_we & mem_oe), 32'h0);
        chk("excl.onehot", 32'({$onehot0(gnt), $onehot0(beat), $onehot0(done), $onehot0(rd_valid)}), 32'hF);
    end

    initial begin
        int order [4];
        order = '{0, 1, 2, 0};
        reset = 1'b1;
        req   = 3'b000;
        rwe   = 3'b000;
        for (int i = 0; i < 3; i++) begin
            ra[i] = '0;
            rl[i] = '0;
            wd[i] = '0;
        end
        #1 reset = 1'b0;
        #1;
        chk("rst.gnt", 32'(gnt), 32'h0);
        chk("rst.done", 32'({done, abort}), 32'h0);
        chk("rst.mem", 32'({mem_addr, mem_we, mem_oe}), 32'h0);
        chk("rst.rd", 32'({rd_data, rd_valid}), 32'h0);
        tick();
        #1 reset = 1'b1;
        tick();

        // Three simultaneous requesters, len 2: order 0,1,2,0 with 2-cycle gaps
        ra[0] = 16'h0020; ra[1] = 16'h0030; ra[2] = 16'h0040;
        rl[0] = 8'd2; rl[1] = 8'd2; rl[2] = 8'd2;
        rwe = 3'b111;
        req = 3'b111;
        for (int b = 0; b < 4; b++) begin
            tick();
            chk("rr.gnt", 32'(gnt), 32'(1 << order[b]));
            chk("rr.addr0", 32'(mem_addr), 32'(16'h0020 + 16'h10 * order[b]));
            chk("rr.done0", 32'(done), 32'h0);
            if (b == 3) req = 3'b001;
            tick();
            chk("rr.done1", 32'(done), 32'(1 << order[b]));
            chk("rr.addr1", 32'(mem_addr), 32'(16'h0021 + 16'h10 * order[b]));
            tick();
            chk_idle("rr.gap1");
            if (b == 3) req = 3'b000;
            tick();
            chk_idle("rr.gap2");
        end

        // Write burst on requester 0
        ra[0] = 16'h0010; rl[0] = 8'd4; rwe = 3'b001; wd[0] = 8'hA0;
        req = 3'b001;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("wr.gnt", 32'(gnt), 32'h1);
            chk("wr.beat", 32'(beat), 32'h1);
            chk("wr.we", 32'({mem_we, mem_oe}), 32'h2);
            chk("wr.addr", 32'(mem_addr), 32'(16'h0010 + k));
            chk("wr.data", 32'(mem_data), 32'(8'hA0 + k));
            chk("wr.done", 32'(done), (k == 3) ? 32'h1 : 32'h0);
            wd[0] = 8'(8'hA1 + k);
        end
        tick();
        chk_idle("wr.rel");
        chk("wr.rel.done", 32'(done), 32'h0);
        req = 3'b000;
        tick();

        // Read burst on requester 1 from 0x0100
        ra[1] = 16'h0100; rl[1] = 8'd3; rwe = 3'b000;
        req = 3'b010;
        tick();
        chk("rd.beat", 32'(beat), 32'h2);
        chk("rd.oe", 32'({mem_we, mem_oe}), 32'h1);
        chk("rd.addr0", 32'(mem_addr), 32'h0100);
        chk("rd.v0", 32'(rd_valid), 32'h0);
        tick();
        chk("rd.addr1", 32'(mem_addr), 32'h0101);
        chk("rd.d0", 32'({rd_valid, rd_data}), 32'h211);
        tick();
        chk("rd.addr2", 32'(mem_addr), 32'h0102);
        chk("rd.done", 32'(done), 32'h2);
        chk("rd.d1", 32'({rd_valid, rd_data}), 32'h222);
        tick();
        chk("rd.d2", 32'({rd_valid, rd_data}), 32'h233);
        chk_idle("rd.rel");
        req = 3'b000;
        tick();
        chk("rd.v3", 32'(rd_valid), 32'h0);

        // Address wrap, then zero-length burst
        ra[0] = 16'hFFFE; rl[0] = 8'd4; rwe = 3'b001; wd[0] = 8'h5A;
        req = 3'b001;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("wrap.addr", 32'(mem_addr), 32'(16'(32'hFFFE + k)));
        end
        chk("wrap.done", 32'(done), 32'h1);
        tick();
        rl[0] = 8'd0;
        tick();
        chk_idle("zl.idle");
        tick();
        chk("zl.done", 32'({done, abort}), 32'h2);
        chk_idle("zl.rel");
        req = 3'b000;
        tick();
        chk("zl.after", 32'(done), 32'h0);

        // Abort requester 2 after 3 beats; requester 0 wins next
        ra[2] = 16'h0200; rl[2] = 8'd10; rwe = 3'b111; wd[2] = 8'hC3;
        ra[0] = 16'h0280; rl[0] = 8'd1;
        ra[1] = 16'h0290; rl[1] = 8'd1;
        req = 3'b100;
        nw = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ab.beat", 32'(beat), 32'h4);
            chk("ab.addr", 32'(mem_addr), 32'(16'h0200 + k));
            nw += int'(mem_we);
        end
        tick();
        req = 3'b011;
        #1;
        nw += int'(mem_we);
        chk("ab.nobeat", 32'(beat), 32'h0);
        chk("ab.done", 32'({done, abort}), 32'h9);
        tick();
        nw += int'(mem_we);
        chk("ab.writes", 32'(nw), 32'd3);
        chk("ab.rel", 32'({gnt, done, abort}), 32'h0);
        tick();
        chk_idle("ab.idle");
        tick();
        chk("ab.next", 32'(gnt), 32'h1);
        chk("ab.next.addr", 32'(mem_addr), 32'h0280);
        chk("ab.next.done", 32'(done), 32'h1);
        tick();
        req = 3'b000;
        tick();

        // Reset in the middle of a burst
        ra[0] = 16'h0300; rl[0] = 8'd8; rwe = 3'b001;
        req = 3'b001;
        tick();
        tick();
        chk("mr.beat", 32'(beat), 32'h1);
        reset = 1'b0;
        #1;
        chk("mr.gnt", 32'({gnt, beat}), 32'h0);
        chk("mr.done", 32'({done, abort}), 32'h0);
        chk("mr.mem", 32'({mem_addr, mem_we, mem_oe}), 32'h0);
        tick();
        chk("mr.hold", 32'({gnt, done}), 32'h0);
        #3 reset = 1'b1;
        tick();
        chk("mr.regrant", 32'(gnt), 32'h1);
        chk("mr.addr", 32'(mem_addr), 32'h0300);
        req = 3'b000;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
